// File: rtl/line_window_ctrl.sv
// Sliding-window controller for a line-buffered KxK convolution front end.
// Tracks pixel position in the frame and flags when the window registers hold a full KxK window.
module line_window_ctrl #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        shift_en,
  output logic        win_valid,
  output logic [15:0] win_row,
  output logic [15:0] win_col,
  output logic        busy,
  output logic        done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_K    = CW'(K - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_wrap;
  logic          last_px;
  logic          win_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    in_ready = (state == RUN);
    accept   = in_valid & in_ready;
    shift_en = accept;
    busy     = (state != IDLE);
    done     = (state == DONE);
    col_wrap = (col == COL_LAST);
    last_px  = col_wrap && (row == ROW_LAST);
    // Rows/cols below K-1 are line-buffer fill; gating here is the only suppression needed.
    win_hit  = accept && (row >= ROW_K) && (col >= COL_K);
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && last_px) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (state != RUN) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= last_px ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      win_valid <= win_hit;
      if (win_hit) begin
        win_row <= 16'(row - ROW_K);
        win_col <= 16'(col - COL_K);
      end
    end
  end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Directed bench for line_window_ctrl: a 4x4/K=3 instance for detailed checks
// and a default 32x32/K=3 instance for whole-frame window counting.
module tb_line_window_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, in_valid;
  logic        in_ready, shift_en, win_valid, busy, done;
  logic [15:0] win_row, win_col;

  logic        start2, in_valid2;
  logic        in_ready2, shift_en2, win_valid2, busy2, done2;
  logic [15:0] win_row2, win_col2;

  int checks = 0;
  int errors = 0;
  int held_r = 0;
  int held_c = 0;
  int exp_acc[4] = '{10, 11, 14, 15};
  int exp_r[4]   = '{0, 0, 1, 1};
  int exp_c[4]   = '{0, 1, 0, 1};

  always #5 clk = ~clk;

  line_window_ctrl #(.IMG_W(4), .IMG_H(4), .K(3)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .shift_en(shift_en), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );

  line_window_ctrl dut32 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2),
    .in_ready(in_ready2), .shift_en(shift_en2), .win_valid(win_valid2),
    .win_row(win_row2), .win_col(win_col2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // prev is the accept index from the previous cycle (-1 if none)
  task automatic chk_win(input int prev, inout int wi);
    if (wi < 4 && prev == exp_acc[wi]) begin
      chk("win_valid_hi", win_valid, 1);
      chk("win_row", win_row, exp_r[wi]);
      chk("win_col", win_col, exp_c[wi]);
      held_r = exp_r[wi];
      held_c = exp_c[wi];
      wi++;
    end else begin
      chk("win_valid_lo", win_valid, 0);
      chk("win_row_hold", win_row, held_r);
      chk("win_col_hold", win_col, held_c);
    end
  endtask

  // Called at posedge+1 with DUT in IDLE; leaves DUT in RUN at posedge+1.
  task automatic start_frame;
    start = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: continuous valid, 1: toggling valid, 2: start pulse mid-frame,
  // 3: start raised near the end and held through DONE.
  task automatic drive_pixels(input int mode, input int max_acc, output int wins);
    int acc  = 0;
    int prev = -1;
    int wi   = 0;
    int cyc  = 0;
    while (acc < max_acc && cyc < 200) begin
      in_valid = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
      if (mode == 2) start = (acc == 5);
      if (mode == 3) start = (acc >= 14);
      @(negedge clk);
      chk("shift_en", shift_en, in_valid);
      chk("in_ready", in_ready, 1);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk_win(prev, wi);
      prev = in_valid ? acc : -1;
      if (in_valid) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("accept_budget", acc, max_acc);
    in_valid = 1'b0;
    if (max_acc == 16) begin
      @(negedge clk);
      chk("stim_cycles", cyc + 1, (mode == 1) ? 32 : 17);
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 1);
      chk("in_ready_done", in_ready, 0);
      chk("shift_en_done", shift_en, 0);
      chk_win(prev, wi);
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("done_after", done, 0);
      chk_win(-1, wi);
      @(posedge clk); #1;
    end
    wins = wi;
  endtask

  initial begin
    int wins;
    int wcount, dcount;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    start2 = 1'b0; in_valid2 = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back frame
    start_frame();
    drive_pixels(0, 16, wins);
    chk("wins_contig", wins, 4);

    // Stalling every other cycle
    start_frame();
    drive_pixels(1, 16, wins);
    chk("wins_toggle", wins, 4);

    // Mid-frame asynchronous reset after 9 accepts
    start_frame();
    drive_pixels(0, 9, wins);
    chk("wins_pre_reset", wins, 0);
    in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_shift_en", shift_en, 0);
    chk("arst_win_valid", win_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_win_row", win_row, 0);
    chk("arst_win_col", win_col, 0);
    @(posedge clk); #1;
    chk("arst_no_done", done, 0);
    reset = 1'b1;
    in_valid = 1'b0;
    held_r = 0; held_c = 0;
    @(posedge clk); #1;
    start_frame();
    drive_pixels(0, 16, wins);
    chk("wins_post_reset", wins, 4);

    // Start pulsed during RUN is ignored
    start_frame();
    drive_pixels(2, 16, wins);
    chk("wins_start_run", wins, 4);

    // Start held through DONE launches the next frame with no new pulse
    start_frame();
    drive_pixels(3, 16, wins);
    chk("wins_start_hold", wins, 4);
    start = 1'b0;
    chk("auto_restart_busy", busy, 1);
    chk("auto_restart_ready", in_ready, 1);
    drive_pixels(0, 16, wins);
    chk("wins_second_frame", wins, 4);

    // Default-size frame
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    in_valid2 = 1'b1;
    wcount = 0; dcount = 0;
    for (int i = 0; i < 1040; i++) begin
      @(negedge clk);
      if (win_valid2) wcount++;
      if (done2) dcount++;
    end
    in_valid2 = 1'b0;
    chk("big_windows", wcount, 900);
    chk("big_dones", dcount, 1);
    chk("big_busy_end", busy2, 0);
    chk("big_last_row", win_row2, 29);
    chk("big_last_col", win_col2, 29);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
